// File: rtl/codes.sv
// Shared type and code definitions for the memory-bus infrastructure.
//   size_t      : 32-bit address/data bus word
//   arb_state_t : bus arbiter state; the encoding doubles as the owner code
//   OWNER_*     : owner codes reported on the arbiter's owner output
package codes;

  typedef logic [31:0] size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_M0   = 2'd1;
  localparam logic [1:0] OWNER_M1   = 2'd2;

endpackage

// File: rtl/avalon_bus_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter. Master 0 is the CPU, master 1 a
// secondary master (loader/debug). One master owns the bus per transfer; the
// grant is held until that transfer completes or the owner withdraws.
//
// Ports
//   clk, reset               : clock, synchronous active-high reset
//   mN_address/read/write/
//   writedata/byteenable     : master N request (N = 0, 1)
//   mN_waitrequest           : stall to master N
//   mN_readdata              : read data to master N (0 when not owner)
//   s_*                      : slave-side request, waitrequest and readdata
//   owner                    : 0 = none, 1 = m0, 2 = m1 (registered)
//
// Parameter
//   FIXED_PRIORITY : 0 = round-robin on contention, 1 = m0 always wins
//
// state  | meaning
// IDLE   | no owner, slave request forced low, both masters stalled
// OWN_M0 | master 0 connected to the slave
// OWN_M1 | master 1 connected to the slave
module avalon_bus_arbiter
  import codes::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  size_t       m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  size_t       m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output size_t       m0_readdata,

  input  size_t       m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  size_t       m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output size_t       m1_readdata,

  output size_t       s_address,
  output logic        s_read,
  output logic        s_write,
  output size_t       s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  size_t       s_readdata,

  output logic [1:0]  owner
);

  arb_state_t state, state_nxt;
  logic [1:0] last_owner, last_owner_nxt;
  logic       m0_req, m1_req;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  // The state encoding is the owner code, so owner is a pure register.
  assign owner = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWNER_M1;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;

    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = 4'h0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;

    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          // Round-robin: whoever did not finish the last transfer goes next.
          if (FIXED_PRIORITY != 0 || last_owner == OWNER_M1)
            state_nxt = OWN_M0;
          else
            state_nxt = OWN_M1;
        end else if (m0_req) begin
          state_nxt = OWN_M0;
        end else if (m1_req) begin
          state_nxt = OWN_M1;
        end
      end

      OWN_M0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
        if (!m0_req) begin
          // Withdrawn request: release without counting it as a transfer.
          state_nxt = IDLE;
        end else if (!s_waitrequest) begin
          state_nxt      = IDLE;
          last_owner_nxt = OWNER_M0;
        end
      end

      OWN_M1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
        if (!m1_req) begin
          state_nxt = IDLE;
        end else if (!s_waitrequest) begin
          state_nxt      = IDLE;
          last_owner_nxt = OWNER_M1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
module tb_avalon_bus_arbiter;
  import codes::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  size_t      m0_address, m1_address, m0_writedata, m1_writedata, s_readdata;
  logic       m0_read, m0_write, m1_read, m1_write, s_waitrequest;
  logic [3:0] m0_byteenable, m1_byteenable;

  // round-robin instance
  logic       m0_waitrequest_rr, m1_waitrequest_rr, s_read_rr, s_write_rr;
  size_t      m0_readdata_rr, m1_readdata_rr, s_address_rr, s_writedata_rr;
  logic [3:0] s_byteenable_rr;
  logic [1:0] owner_rr;
  // fixed-priority instance
  logic       m0_waitrequest_fp, m1_waitrequest_fp, s_read_fp, s_write_fp;
  size_t      m0_readdata_fp, m1_readdata_fp, s_address_fp, s_writedata_fp;
  logic [3:0] s_byteenable_fp;
  logic [1:0] owner_fp;

  avalon_bus_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest_rr), .m0_readdata(m0_readdata_rr),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest_rr), .m1_readdata(m1_readdata_rr),
    .s_address(s_address_rr), .s_read(s_read_rr), .s_write(s_write_rr),
    .s_writedata(s_writedata_rr), .s_byteenable(s_byteenable_rr),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .owner(owner_rr)
  );

  avalon_bus_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest_fp), .m0_readdata(m0_readdata_fp),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest_fp), .m1_readdata(m1_readdata_fp),
    .s_address(s_address_fp), .s_read(s_read_fp), .s_write(s_write_fp),
    .s_writedata(s_writedata_fp), .s_byteenable(s_byteenable_fp),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .owner(owner_fp)
  );

  typedef struct packed {
    logic [1:0]  own;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t sb[$];
  xfer_t mon_exp;
  int    n_vec = 0;
  int    n_err = 0;
  logic  mon_sel = 1'b0;

  // Monitor view of whichever instance is under test.
  logic [1:0] mo;
  logic       ms_read, ms_write;
  size_t      ms_address, ms_writedata, mm0_rd, mm1_rd, own_rd, oth_rd;
  logic [3:0] ms_be;
  always_comb begin
    if (mon_sel) begin
      mo = owner_fp; ms_read = s_read_fp; ms_write = s_write_fp;
      ms_address = s_address_fp; ms_writedata = s_writedata_fp; ms_be = s_byteenable_fp;
      mm0_rd = m0_readdata_fp; mm1_rd = m1_readdata_fp;
    end else begin
      mo = owner_rr; ms_read = s_read_rr; ms_write = s_write_rr;
      ms_address = s_address_rr; ms_writedata = s_writedata_rr; ms_be = s_byteenable_rr;
      mm0_rd = m0_readdata_rr; mm1_rd = m1_readdata_rr;
    end
    own_rd = (mo == OWNER_M1) ? mm1_rd : mm0_rd;
    oth_rd = (mo == OWNER_M1) ? mm0_rd : mm1_rd;
  end

  // Completed transfers are popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!reset && mo != OWNER_NONE && (ms_read || ms_write) && !s_waitrequest) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: owner=%0d addr=%h, required no transfer", mo, ms_address);
      end else begin
        mon_exp = sb.pop_front();
        if ({mo, ms_address, ms_write, ms_writedata, ms_be} !==
            {mon_exp.own, mon_exp.addr, mon_exp.wr, mon_exp.wdata, mon_exp.be}) begin
          n_err++;
          $display("FAIL sb_xfer: got own=%0d a=%h w=%b d=%h be=%h, required own=%0d a=%h w=%b d=%h be=%h",
                   mo, ms_address, ms_write, ms_writedata, ms_be,
                   mon_exp.own, mon_exp.addr, mon_exp.wr, mon_exp.wdata, mon_exp.be);
        end
        if (!mon_exp.wr) begin
          n_vec++;
          if (own_rd !== mon_exp.rdata) begin
            n_err++;
            $display("FAIL sb_rdata: got %h, required %h", own_rd, mon_exp.rdata);
          end
        end
        n_vec++;
        if (oth_rd !== 32'h0) begin
          n_err++;
          $display("FAIL sb_nonowner_rdata: got %h, required 00000000", oth_rd);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = 4'h0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = 4'h0;
    s_waitrequest = 1'b0; s_readdata = '0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic check_sb_empty(input string name);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_sb_left: %0d pending, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    s_readdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if ({owner_rr, s_read_rr, s_write_rr, m0_waitrequest_rr, m1_waitrequest_rr,
           s_address_rr, s_writedata_rr, s_byteenable_rr, m0_readdata_rr, m1_readdata_rr} !==
          {2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0}) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: own=%0d rd=%b wr=%b w0=%b w1=%b a=%h r0=%h r1=%h, required idle zeros, waits 1",
                 i, owner_rr, s_read_rr, s_write_rr, m0_waitrequest_rr, m1_waitrequest_rr,
                 s_address_rr, m0_readdata_rr, m1_readdata_rr);
      end
      cyc();
    end
  endtask

  task automatic test_read_wait();
    do_reset();
    mon_sel = 1'b0;
    m0_address = 32'hBFC0_0000; m0_byteenable = 4'hF; m0_read = 1'b1;
    s_waitrequest = 1'b1;
    sb.push_back('{OWNER_M0, 32'hBFC0_0000, 1'b0, 32'h0, 4'hF, 32'h3C02_1234});
    @(negedge clk);
    n_vec++;
    if (owner_rr !== 2'd0 || s_read_rr !== 1'b0 || m0_waitrequest_rr !== 1'b1) begin
      n_err++;
      $display("FAIL read_latency: own=%0d s_read=%b w0=%b, required 0 0 1",
               owner_rr, s_read_rr, m0_waitrequest_rr);
    end
    cyc();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin s_waitrequest = 1'b0; s_readdata = 32'h3C02_1234; end
      @(negedge clk);
      n_vec++;
      if (owner_rr !== 2'd1 || s_read_rr !== 1'b1 || s_address_rr !== 32'hBFC0_0000 ||
          m0_waitrequest_rr !== (i < 3) || m1_waitrequest_rr !== 1'b1) begin
        n_err++;
        $display("FAIL read_own[%0d]: own=%0d s_read=%b a=%h w0=%b w1=%b, required 1 1 bfc00000 %b 1",
                 i, owner_rr, s_read_rr, s_address_rr, m0_waitrequest_rr, m1_waitrequest_rr, (i < 3));
      end
      cyc();
    end
    m0_read = 1'b0;
    @(negedge clk);
    n_vec++;
    if (owner_rr !== 2'd0 || s_read_rr !== 1'b0 || m0_readdata_rr !== 32'h0 ||
        m0_waitrequest_rr !== 1'b1) begin
      n_err++;
      $display("FAIL read_release: own=%0d s_read=%b r0=%h w0=%b, required 0 0 00000000 1",
               owner_rr, s_read_rr, m0_readdata_rr, m0_waitrequest_rr);
    end
    check_sb_empty("read_wait");
  endtask

  task automatic test_contention_rr();
    logic [1:0] seq [5];
    seq = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1};
    do_reset();
    mon_sel = 1'b0;
    s_waitrequest = 1'b0; s_readdata = 32'h1111_2222;
    m0_address = 32'h1000; m1_address = 32'h2000;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_read = 1'b1; m1_read = 1'b1;
    sb.push_back('{OWNER_M0, 32'h1000, 1'b0, 32'h0, 4'hF, 32'h1111_2222});
    sb.push_back('{OWNER_M1, 32'h2000, 1'b0, 32'h0, 4'hF, 32'h1111_2222});
    sb.push_back('{OWNER_M0, 32'h1000, 1'b0, 32'h0, 4'hF, 32'h1111_2222});
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      n_vec++;
      if (owner_rr !== seq[i] ||
          (seq[i] == 2'd1 && m1_waitrequest_rr !== 1'b1) ||
          (seq[i] == 2'd2 && m0_waitrequest_rr !== 1'b1)) begin
        n_err++;
        $display("FAIL rr_order[%0d]: own=%0d w0=%b w1=%b, required own=%0d, loser stalled",
                 i, owner_rr, m0_waitrequest_rr, m1_waitrequest_rr, seq[i]);
      end
    end
    #1;
    m0_read = 1'b0; m1_read = 1'b0;
    cyc();
    @(negedge clk);
    n_vec++;
    if (owner_rr !== 2'd0) begin
      n_err++;
      $display("FAIL rr_release: own=%0d, required 0", owner_rr);
    end
    check_sb_empty("contention_rr");
  endtask

  task automatic test_fixed_priority();
    do_reset();
    cyc();
    mon_sel = 1'b1;
    s_waitrequest = 1'b0; s_readdata = 32'h1111_2222;
    m0_address = 32'h1000; m1_address = 32'h2000;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_read = 1'b1; m1_read = 1'b1;
    for (int i = 0; i < 4; i++)
      sb.push_back('{OWNER_M0, 32'h1000, 1'b0, 32'h0, 4'hF, 32'h1111_2222});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if (m1_waitrequest_fp !== 1'b1 || owner_fp === 2'd2) begin
        n_err++;
        $display("FAIL fp_m1_stall[%0d]: w1=%b own=%0d, required w1=1, owner never 2",
                 i, m1_waitrequest_fp, owner_fp);
      end
      if (i < 7) cyc();
    end
    #1;
    m0_read = 1'b0; m1_read = 1'b0;
    cyc();
    mon_sel = 1'b0;
    check_sb_empty("fixed_priority");
  endtask

  task automatic test_write_m1();
    do_reset();
    mon_sel = 1'b0;
    m1_address = 32'h40; m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'h3; m1_write = 1'b1;
    s_waitrequest = 1'b1;
    sb.push_back('{OWNER_M1, 32'h40, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h0});
    @(negedge clk);
    n_vec++;
    if (owner_rr !== 2'd0 || s_write_rr !== 1'b0 || m0_waitrequest_rr !== 1'b1) begin
      n_err++;
      $display("FAIL wr_idle: own=%0d s_write=%b w0=%b, required 0 0 1",
               owner_rr, s_write_rr, m0_waitrequest_rr);
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if ({s_write_rr, s_read_rr, s_address_rr, s_writedata_rr, s_byteenable_rr,
         m0_waitrequest_rr, m1_waitrequest_rr} !==
        {1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 4'h3, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL wr_fwd: w=%b r=%b a=%h d=%h be=%h w0=%b w1=%b, required 1 0 40 deadbeef 3 1 1",
               s_write_rr, s_read_rr, s_address_rr, s_writedata_rr, s_byteenable_rr,
               m0_waitrequest_rr, m1_waitrequest_rr);
    end
    cyc();
    s_waitrequest = 1'b0;
    @(negedge clk);
    n_vec++;
    if (m1_waitrequest_rr !== 1'b0 || m0_waitrequest_rr !== 1'b1) begin
      n_err++;
      $display("FAIL wr_done: w1=%b w0=%b, required 0 1", m1_waitrequest_rr, m0_waitrequest_rr);
    end
    cyc();
    m1_write = 1'b0;
    @(negedge clk);
    n_vec++;
    if (owner_rr !== 2'd0 || s_write_rr !== 1'b0 || m0_waitrequest_rr !== 1'b1) begin
      n_err++;
      $display("FAIL wr_release: own=%0d s_write=%b w0=%b, required 0 0 1",
               owner_rr, s_write_rr, m0_waitrequest_rr);
    end
    check_sb_empty("write_m1");
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_address = 32'h80; m1_writedata = 32'h1234_5678; m1_byteenable = 4'hF; m1_write = 1'b1;
    s_waitrequest = 1'b1;
    cyc();
    @(negedge clk);
    n_vec++;
    if (owner_rr !== 2'd2 || s_write_rr !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_own: own=%0d s_write=%b, required 2 1", owner_rr, s_write_rr);
    end
    cyc();
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (owner_rr !== 2'd2) begin
      n_err++;
      $display("FAIL rstmid_sync: own=%0d before edge, required 2", owner_rr);
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if (owner_rr !== 2'd0 || s_write_rr !== 1'b0 || m0_waitrequest_rr !== 1'b1 ||
        m1_waitrequest_rr !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_drop: own=%0d s_write=%b w0=%b w1=%b, required 0 0 1 1",
               owner_rr, s_write_rr, m0_waitrequest_rr, m1_waitrequest_rr);
    end
    m1_write = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    m0_address = 32'h1000; m0_read = 1'b1; s_waitrequest = 1'b1;
    cyc();
    cyc();
    m0_read = 1'b0;
    @(negedge clk);
    n_vec++;
    if (owner_rr !== 2'd1 || s_read_rr !== 1'b0) begin
      n_err++;
      $display("FAIL abort_drop: own=%0d s_read=%b, required 1 0", owner_rr, s_read_rr);
    end
    cyc();
    @(negedge clk);
    n_vec++;
    if (owner_rr !== 2'd0) begin
      n_err++;
      $display("FAIL abort_idle: own=%0d, required 0", owner_rr);
    end
    m0_read = 1'b1; m1_read = 1'b1; m1_address = 32'h2000;
    cyc();
    @(negedge clk);
    n_vec++;
    if (owner_rr !== 2'd1) begin
      n_err++;
      $display("FAIL abort_last_owner: own=%0d, required 1 (abort leaves last owner m1)", owner_rr);
    end
    #1;
    m0_read = 1'b0; m1_read = 1'b0;
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read_wait();
    test_contention_rr();
    test_fixed_priority();
    test_write_m1();
    test_reset_mid();
    test_abort();
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
